// File: rtl/uart_transmitter.sv
// uart_transmitter
// Serial 8N1 transmitter with a small byte FIFO in front of it.
// Each frame: start bit (0), 8 data bits LSB first, stop bit (1). Every
// bit lasts P clocks, where P is clks_per_bit_i latched at frame start
// (0 is treated as 1). Back-to-back frames leave no idle gap on the line.
//
// Ports:
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   clks_per_bit_i  clocks per serial bit, sampled at each frame start
//   tx_valid_i      push request for tx_byte_i
//   tx_byte_i       byte to queue
//   tx_ready_o      FIFO not full (decoded from the count register)
//   tx_serial_o     serial line, idles high (registered)
//   tx_active_o     frame in progress (registered)
//   tx_done_o       one-cycle pulse during the last stop-bit cycle (registered)
//   fifo_level_o    bytes queued, not counting the byte on the wire

module uart_transmitter #(
  parameter int Depth = 4,
  parameter int CntW  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [CntW-1:0]          clks_per_bit_i,
  input  logic                     tx_valid_i,
  input  logic [7:0]               tx_byte_i,
  output logic                     tx_ready_o,
  output logic                     tx_serial_o,
  output logic                     tx_active_o,
  output logic                     tx_done_o,
  output logic [$clog2(Depth):0]   fifo_level_o
);

  localparam int AW = $clog2(Depth);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]   LvlFull = LW'(Depth);
  localparam logic [LW-1:0]   LvlOne  = LW'(1);
  localparam logic [LW-1:0]   LvlZero = LW'(0);
  localparam logic [AW-1:0]   PtrOne  = AW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntZero = CntW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]      r_mem [Depth];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_count;

  // Frame sequencing
  state_t          r_state;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] r_period;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_serial;
  logic            r_active;
  logic            r_done;

  logic            w_push;
  logic            w_pop;
  logic            w_fifo_nonempty;
  logic            w_bit_last;
  state_t          w_next_state;
  logic [CntW-1:0] w_cnt_n;
  logic [CntW-1:0] w_period_n;
  logic [CntW-1:0] w_divisor;
  logic [2:0]      w_idx_n;
  logic [7:0]      w_shift_n;
  logic            w_serial_n;
  logic            w_active_n;
  logic            w_done_n;

  // No pass-through: a full FIFO refuses a push even if it pops this cycle.
  assign tx_ready_o      = (r_count != LvlFull);
  assign w_push          = tx_valid_i && tx_ready_o;
  assign w_fifo_nonempty = (r_count != LvlZero);
  assign w_bit_last      = (r_cnt == (r_period - CntOne));
  assign w_divisor       = (clks_per_bit_i == CntZero) ? CntOne : clks_per_bit_i;

  assign tx_serial_o  = r_serial;
  assign tx_active_o  = r_active;
  assign tx_done_o    = r_done;
  assign fifo_level_o = r_count;

  // FIFO data write; storage needs no reset since the pointers guard reads
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_byte_i;
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LvlOne;
        2'b01:   r_count <= r_count - LvlOne;
        default: r_count <= r_count;
      endcase
    end
  end

  // Next-state, datapath and next-output decode
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_cnt_n      = r_cnt + CntOne;
    w_period_n   = r_period;
    w_idx_n      = r_idx;
    w_shift_n    = r_shift;

    case (r_state)
      IDLE: begin
        w_cnt_n = CntZero;
        if (w_fifo_nonempty) begin
          w_pop        = 1'b1;
          w_shift_n    = r_mem[r_rd_ptr];
          w_period_n   = w_divisor;
          w_next_state = START;
        end else begin
          w_next_state = IDLE;
        end
      end
      START: begin
        if (w_bit_last) begin
          w_cnt_n      = CntZero;
          w_idx_n      = 3'd0;
          w_next_state = DATA;
        end else begin
          w_next_state = START;
        end
      end
      DATA: begin
        if (w_bit_last) begin
          w_cnt_n   = CntZero;
          w_shift_n = {1'b0, r_shift[7:1]};
          if (r_idx == 3'd7) begin
            w_next_state = STOP;
          end else begin
            w_idx_n = r_idx + 3'd1;
          end
        end else begin
          w_next_state = DATA;
        end
      end
      STOP: begin
        if (w_bit_last) begin
          w_cnt_n = CntZero;
          if (w_fifo_nonempty) begin
            w_pop        = 1'b1;
            w_shift_n    = r_mem[r_rd_ptr];
            w_period_n   = w_divisor;
            w_next_state = START;
          end else begin
            w_next_state = IDLE;
          end
        end else begin
          w_next_state = STOP;
        end
      end
      default: begin
        w_cnt_n      = CntZero;
        w_next_state = IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (w_next_state)
      START:   w_serial_n = 1'b0;
      DATA:    w_serial_n = w_shift_n[0];
      default: w_serial_n = 1'b1;
    endcase
    w_active_n = (w_next_state != IDLE);
    // Pulse is registered one edge early so it covers the final stop cycle.
    w_done_n   = (w_next_state == STOP) && (w_cnt_n == (w_period_n - CntOne));
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_period <= CntOne;
      r_idx    <= 3'd0;
      r_shift  <= 8'd0;
      r_serial <= 1'b1;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_cnt_n;
      r_period <= w_period_n;
      r_idx    <= w_idx_n;
      r_shift  <= w_shift_n;
      r_serial <= w_serial_n;
      r_active <= w_active_n;
      r_done   <= w_done_n;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a frame-level model predicts
// every output each cycle; directed tasks pin exact bit patterns and timing.

module tb_uart_transmitter;

  localparam int DEPTH = 4;
  localparam int CNTW  = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [CNTW-1:0] clks_per_bit_i = 16'd4;
  logic            tx_valid_i = 1'b0;
  logic [7:0]      tx_byte_i = 8'd0;
  logic            tx_ready_o;
  logic            tx_serial_o;
  logic            tx_active_o;
  logic            tx_done_o;
  logic [2:0]      fifo_level_o;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int done_q[$];

  // Model state: queued bytes, current frame bits, bit period, position in frame
  logic [7:0] m_q[$];
  logic       m_busy = 1'b0;
  logic [9:0] m_frame = 10'h3FF;
  int         m_p = 1;
  int         m_k = 0;

  uart_transmitter #(.Depth(DEPTH), .CntW(CNTW)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clks_per_bit_i(clks_per_bit_i),
    .tx_valid_i    (tx_valid_i),
    .tx_byte_i     (tx_byte_i),
    .tx_ready_o    (tx_ready_o),
    .tx_serial_o   (tx_serial_o),
    .tx_active_o   (tx_active_o),
    .tx_done_o     (tx_done_o),
    .fifo_level_o  (fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: a frame is 10 bits of P cycles each.
  initial begin
    int  pre;
    bit  do_push;
    bit  start;
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        m_q.delete();
        m_busy = 1'b0;
        m_k = 0;
      end else begin
        pre     = m_q.size();
        do_push = tx_valid_i && (pre < DEPTH);
        start   = 1'b0;
        if (!m_busy) begin
          start = (pre > 0);
        end else if (m_k == 10 * m_p - 1) begin
          m_busy = 1'b0;
          start  = (pre > 0);
        end else begin
          m_k++;
        end
        if (start) begin
          m_frame = {1'b1, m_q.pop_front(), 1'b0};
          m_p     = (clks_per_bit_i == 16'd0) ? 1 : int'(clks_per_bit_i);
          m_k     = 0;
          m_busy  = 1'b1;
        end
        if (do_push) m_q.push_back(tx_byte_i);
      end
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("serial", {31'd0, tx_serial_o}, {31'd0, m_busy ? m_frame[m_k / m_p] : 1'b1});
      chk("active", {31'd0, tx_active_o}, {31'd0, m_busy});
      chk("done",   {31'd0, tx_done_o},   {31'd0, m_busy && (m_k == 10 * m_p - 1)});
      chk("level",  {29'd0, fifo_level_o}, m_q.size());
      chk("ready",  {31'd0, tx_ready_o},  {31'd0, m_q.size() != DEPTH});
      if (tx_done_o === 1'b1) done_q.push_back(cyc);
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic push(input logic [7:0] b, output int stall);
    stall = 0;
    tx_valid_i = 1'b1;
    tx_byte_i  = b;
    while (!tx_ready_o && stall < 2000) begin
      @(negedge clk_i);
      stall++;
    end
    if (stall >= 2000) begin
      n_checks++;
      n_errs++;
      $display("FAIL push_timeout: got ready=0 expected ready=1");
    end
    @(negedge clk_i);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || m_q.size() != 0) && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 5000) begin
      n_checks++;
      n_errs++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
    @(negedge clk_i);
  endtask

  // Single-byte frame with hand-written bit pattern (bit 0 = first on wire)
  task automatic frame_capture(input logic [7:0] b, input logic [15:0] p_cfg,
                               input logic [9:0] pattern, input string name);
    int p;
    int done_at;
    wait_idle();
    clks_per_bit_i = p_cfg;
    tx_valid_i = 1'b1;
    tx_byte_i  = b;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    @(posedge clk_i);
    p = (p_cfg == 16'd0) ? 1 : int'(p_cfg);
    done_at = -1;
    for (int j = 0; j < 10 * p; j++) begin
      @(negedge clk_i);
      chk({name, "_bit"}, {31'd0, tx_serial_o}, {31'd0, pattern[j / p]});
      if (tx_done_o === 1'b1) done_at = j;
    end
    chk({name, "_done_cycle"}, done_at, 10 * p - 1);
    @(negedge clk_i);
    chk({name, "_active_after"}, {31'd0, tx_active_o}, 32'd0);
    chk({name, "_line_after"}, {31'd0, tx_serial_o}, 32'd1);
  endtask

  initial begin
    int st;
    #12;
    chk("rst_serial", {31'd0, tx_serial_o}, 32'd1);
    chk("rst_active", {31'd0, tx_active_o}, 32'd0);
    chk("rst_done",   {31'd0, tx_done_o},   32'd0);
    chk("rst_ready",  {31'd0, tx_ready_o},  32'd1);
    chk("rst_level",  {29'd0, fifo_level_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);

    // 0xA5 at P=4, and 0x81 with divisor 0 (1-cycle bits)
    frame_capture(8'hA5, 16'd4, 10'b1101001010, "a5_p4");
    frame_capture(8'h81, 16'd0, 10'b1100000010, "x81_p0");

    // Three back-to-back frames at P=2
    wait_idle();
    clks_per_bit_i = 16'd2;
    done_q.delete();
    push(8'h00, st);
    push(8'hFF, st);
    push(8'h3C, st);
    tx_valid_i = 1'b0;
    wait_idle();
    chk("b2b_pulses", done_q.size(), 3);
    if (done_q.size() == 3) begin
      chk("b2b_gap1", done_q[1] - done_q[0], 20);
      chk("b2b_gap2", done_q[2] - done_q[1], 20);
    end

    // Six pushes with valid held high at P=8: the sixth waits for the next pop
    clks_per_bit_i = 16'd8;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), st);
    push(8'h5A, st);
    tx_valid_i = 1'b0;
    chk("full_stall_cycles", st, 77);
    wait_idle();

    // Divisor change mid-frame applies only to the next frame
    clks_per_bit_i = 16'd4;
    done_q.delete();
    push(8'hC3, st);
    push(8'h96, st);
    tx_valid_i = 1'b0;
    repeat (12) @(negedge clk_i);
    clks_per_bit_i = 16'd10;
    wait_idle();
    chk("div_pulses", done_q.size(), 2);
    if (done_q.size() == 2) chk("div_frame2_len", done_q[1] - done_q[0], 100);

    // Randomised pushes and divisor changes
    for (int i = 0; i < 800; i++) begin
      tx_valid_i = ($urandom_range(0, 3) == 0);
      tx_byte_i  = 8'($urandom);
      if ($urandom_range(0, 39) == 0) clks_per_bit_i = 16'($urandom_range(0, 3));
      @(negedge clk_i);
    end
    tx_valid_i = 1'b0;
    wait_idle();

    // Asynchronous reset mid-DATA with two bytes queued
    clks_per_bit_i = 16'd4;
    push(8'h11, st);
    push(8'h22, st);
    push(8'h33, st);
    tx_valid_i = 1'b0;
    repeat (14) @(negedge clk_i);
    chk("pre_rst_level", {29'd0, fifo_level_o}, 32'd2);
    chk("pre_rst_active", {31'd0, tx_active_o}, 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_serial", {31'd0, tx_serial_o}, 32'd1);
    chk("arst_level",  {29'd0, fifo_level_o}, 32'd0);
    chk("arst_ready",  {31'd0, tx_ready_o},  32'd1);
    chk("arst_active", {31'd0, tx_active_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (40) @(negedge clk_i);
    chk("post_rst_active", {31'd0, tx_active_o}, 32'd0);
    chk("post_rst_line",   {31'd0, tx_serial_o}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serial 8N1 UART transmitter; the sending-end counterpart of the programming-path uart_receiver.
- Carries boot-loader acknowledges and status bytes from the ICCM programming logic back to the host over a dedicated TX pin.
- Contains a small byte FIFO with a valid/ready push interface and a runtime-programmable baud divisor.
- Transmit order per frame: start bit (0), 8 data bits LSB first, 1 stop bit (1).

Parameters:
- Depth, 4, number of byte entries in the TX FIFO; power of two, minimum 2.
- CntW, 16, width of the baud divisor and bit-period counter.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  reset, asynchronous, active-low
- clks_per_bit_i  input  CntW  clock cycles per serial bit; sampled at each frame start
- tx_valid_i  input  1  push request for tx_byte_i
- tx_byte_i  input  8  byte to transmit
- tx_ready_o  output  1  FIFO can accept a byte (not full)
- tx_serial_o  output  1  serial line; idles high
- tx_active_o  output  1  frame in progress (START, DATA or STOP state)
- tx_done_o  output  1  single-cycle pulse at end of each stop bit
- fifo_level_o  output  $clog2(Depth)+1  number of bytes queued, excluding the byte on the wire

Behaviour:
- Reset (asynchronous, active-low) forces these values immediately:
  - tx_serial_o=1, tx_active_o=0, tx_done_o=0, tx_ready_o=1, fifo_level_o=0.
  - FIFO pointers cleared; FSM=IDLE.
  - Reset mid-frame aborts the frame and returns the line high at once; nothing resumes after reset release.
- All outputs are registered, except tx_ready_o, which is decoded from the FIFO count register.
- Push: a byte is written when tx_valid_i && tx_ready_o at a rising edge.
  - tx_ready_o = (level != Depth).
  - No pass-through: a full FIFO refuses a push even when a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves the level unchanged.
  - Read and write pointers wrap modulo Depth.
- Divisor latch: at each frame start, clks_per_bit_i is latched into an internal bit-period register.
  - A latched value of 0 is treated as 1.
  - Changes to clks_per_bit_i mid-frame have no effect until the next frame.
- FSM states:
  - IDLE: line high. If the FIFO is non-empty: pop the head into a shift register, latch the divisor, clear the bit counter, go to START.
  - START: line 0 for P cycles (P = latched divisor), then go to DATA with bit index 0.
  - DATA: line = shift[0] for P cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: line 1 for P cycles. On the last cycle, pulse tx_done_o. Then:
    - if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Timing:
  - Push accepted at edge E0 into an empty FIFO with the FSM idle: the pop happens at E1, and tx_serial_o is low from E1 for exactly P cycles.
  - Full frame = 10*P cycles.
  - tx_done_o is high for the single cycle ending at edge E1+10P.
  - tx_active_o is high from E1 through the end of the stop bit. It stays continuously high across back-to-back frames.
- The bit-period counter counts 0..P-1; there is no overflow for any P up to 2^CntW-1.
- The pushing side must not rely on back-pressure while idle: with Depth>=2, the FIFO accepts Depth bytes without stalling.

Test Plan:
- Single byte 0xA5, clks_per_bit_i=4, push once from idle: tx_serial_o pattern per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1; one tx_done_o pulse 40 cycles after the pop; tx_active_o=0 afterwards.
- Three bytes 0x00,0xFF,0x3C pushed on consecutive cycles, P=2: three contiguous 20-cycle frames with no idle gap; tx_done_o pulses at 20, 40, 60 cycles after the first pop; fifo_level_o sequence 1,2(,1),…,0.
- Depth=4, P=8, push 6 bytes with tx_valid_i held high: first pushed byte popped immediately; tx_ready_o drops once 4 bytes are queued; the remaining byte is accepted only after the next frame's pop; all 6 bytes transmitted in order.
- Change clks_per_bit_i from 4 to 10 during the DATA bits of a frame: current frame keeps 4-cycle bits; next frame uses 10-cycle bits.
- Assert rst_ni low mid-DATA with 2 bytes queued: tx_serial_o=1 and fifo_level_o=0 immediately (no clock edge needed); after release the line stays high with no frame.
- clks_per_bit_i=0, byte 0x81: frame transmitted with 1-cycle bits (10 cycles total), pattern 0,1,0,0,0,0,0,0,1,1.
